// File: rtl/calc_pkg.sv
// ============================================================================
// calc_pkg : shared state/op encodings and constants for the calculator core
// Rev 1.0
// ============================================================================
`default_nettype none

package calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTER_A = 3'd1,
    ST_ENTER_B = 3'd2,
    ST_CALC    = 3'd3,
    ST_SHOW    = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  // Key vector layout: [9:0] digits, [13:10] ops, [14] eq, [15] clr
  localparam int NUM_KEYS = 16;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/calc_seqarith.sv
// ============================================================================
// calc_seqarith : multicycle shift-add multiplier (restoring divider with CALC_DIV_EN)
// Rev 1.0
// ============================================================================
`default_nettype none

module calc_seqarith
  import calc_pkg::*;
#(
  parameter int VAL_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] a,
  input  logic [VAL_W-1:0] b,
  input  op_t              op,
  input  logic             abort,
  output logic             done,
  output logic [VAL_W-1:0] result,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(VAL_W);
  localparam logic [2*VAL_W-1:0] MAX_WIDE = (2*VAL_W)'(MAX_VAL);

  logic               run_q;
  logic               done_q;
  logic [CW-1:0]      iter_q;
  logic [2*VAL_W-1:0] prod_q;
  logic [2*VAL_W-1:0] mcand_q;
  logic [VAL_W-1:0]   mplier_q;
  logic               accept;

`ifdef CALC_DIV_EN
  assign accept = start && (op == OP_MUL || op == OP_DIV);
`else
  assign accept = start && (op == OP_MUL);
`endif

  // One operand bit per cycle; done is registered so the final partial sum is settled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= 1'b0;
      done_q   <= 1'b0;
      iter_q   <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (abort) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        run_q    <= 1'b1;
        iter_q   <= CW'(VAL_W - 1);
        prod_q   <= '0;
        mcand_q  <= {{VAL_W{1'b0}}, a};
        mplier_q <= b;
      end else if (run_q) begin
        if (mplier_q[0]) prod_q <= prod_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        if (iter_q == '0) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end else begin
          iter_q <= iter_q - 1'b1;
        end
      end
    end
  end

`ifdef CALC_DIV_EN
  logic             div_q;
  logic             dz_q;
  logic [VAL_W-1:0] rem_q;
  logic [VAL_W-1:0] quot_q;
  logic [VAL_W-1:0] dvsr_q;
  logic [VAL_W:0]   rem_sh;
  logic [VAL_W-1:0] rem_diff;
  logic             rem_ge;

  always_comb begin
    rem_sh   = {rem_q, quot_q[VAL_W-1]};
    rem_ge   = rem_sh >= {1'b0, dvsr_q};
    rem_diff = rem_sh[VAL_W-1:0] - dvsr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= 1'b0;
      dz_q   <= 1'b0;
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
    end else if (accept) begin
      div_q  <= (op == OP_DIV);
      dz_q   <= (b == '0);
      rem_q  <= '0;
      quot_q <= a;
      dvsr_q <= b;
    end else if (run_q && !abort) begin
      rem_q  <= rem_ge ? rem_diff : rem_sh[VAL_W-1:0];
      quot_q <= {quot_q[VAL_W-2:0], rem_ge};
    end
  end

  assign result = div_q ? quot_q : prod_q[VAL_W-1:0];
  assign ovf    = div_q ? dz_q : (prod_q > MAX_WIDE);
`else
  assign result = prod_q[VAL_W-1:0];
  assign ovf    = prod_q > MAX_WIDE;
`endif

  assign done = done_q;
  assign busy = run_q;

endmodule

`default_nettype wire

// File: rtl/calc_entry_core.sv
// ============================================================================
// calc_entry_core : key sync/edge detect, decimal operand entry and sign-magnitude
// arithmetic FSM. Optional divide enabled by macro CALC_DIV_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module calc_entry_core
  import calc_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int VAL_W       = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [9:0]                   key_digit,
  input  logic [3:0]                   key_op,
  input  logic                         key_eq,
  input  logic                         key_clr,
  output logic [VAL_W-1:0]             disp_mag,
  output logic                         disp_neg,
  output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
  output logic [2:0]                   state,
  output logic                         busy,
  output logic                         res_valid,
  output logic                         err
);

  localparam int CNT_W   = $clog2(DIGITS + 1);
  localparam int MAX_VAL = pow10(DIGITS) - 1;
  localparam logic [VAL_W:0] MAX_EXT = (VAL_W + 1)'(MAX_VAL);
`ifdef CALC_DIV_EN
  localparam logic [3:0] OP_MASK = 4'b1111;
`else
  localparam logic [3:0] OP_MASK = 4'b0111;
`endif

  // ---------------- key synchroniser and rising-edge detect ----------------
  logic [NUM_KEYS-1:0] keys_raw;
  logic [NUM_KEYS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_KEYS-1:0] prev_q;
  logic [NUM_KEYS-1:0] ev;

  assign keys_raw = {key_clr, key_eq, key_op, key_digit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= keys_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ev = sync_q[SYNC_STAGES-1] & ~prev_q;

  logic [9:0] dig_ev;
  logic [3:0] op_ev;
  logic       eq_ev, clr_ev, dig_ok, op_ok;
  logic [3:0] dig_val;
  logic [1:0] op_idx;
  op_t        op_val;

  assign dig_ev = ev[9:0];
  assign op_ev  = ev[13:10] & OP_MASK;
  assign eq_ev  = ev[14];
  assign clr_ev = ev[15];
  assign dig_ok = $onehot(dig_ev);
  assign op_ok  = $onehot(op_ev);
  assign op_val = op_t'(op_idx);

  always_comb begin
    dig_val = '0;
    op_idx  = '0;
    for (int i = 0; i < 10; i++) if (dig_ev[i]) dig_val = 4'(i);
    for (int i = 0; i < 4; i++)  if (op_ev[i])  op_idx  = 2'(i);
  end

  // ---------------- datapath registers ----------------
  state_t           state_q, state_d;
  logic [VAL_W-1:0] acc_q, a_mag_q, b_mag_q;
  logic [CNT_W-1:0] cnt_q;
  logic             a_neg_q, b_neg_q, chain_q, err_q, res_valid_q;
  op_t              op_q, pend_op_q;

  // Digit append; IDLE/SHOW start a fresh operand, leading zeros are not counted
  logic             fresh;
  logic [VAL_W-1:0] base_acc, dig_acc;
  logic [CNT_W-1:0] base_cnt, dig_cnt;

  always_comb begin
    fresh    = (state_q == ST_IDLE) || (state_q == ST_SHOW);
    base_acc = fresh ? '0 : acc_q;
    base_cnt = fresh ? '0 : cnt_q;
    dig_acc  = base_acc;
    dig_cnt  = base_cnt;
    if (base_cnt < CNT_W'(DIGITS)) begin
      dig_acc = base_acc * VAL_W'(10) + VAL_W'(dig_val);
      dig_cnt = (base_cnt == '0 && dig_val == 4'd0) ? '0 : base_cnt + 1'b1;
    end
  end

  // Second operand: typed value, or A itself when nothing was typed
  logic [VAL_W-1:0] b_sel;
  logic             b_neg_sel;
  assign b_sel     = (cnt_q != '0) ? acc_q : a_mag_q;
  assign b_neg_sel = (cnt_q != '0) ? 1'b0 : a_neg_q;

  // ---------------- add/sub and result select ----------------
  logic             b_neg_eff, is_seq;
  logic [VAL_W:0]   a_ext, b_ext, as_mag;
  logic             as_neg;
  logic [VAL_W-1:0] res_mag;
  logic             res_neg, res_ovf;
  logic             sa_done, sa_ovf, sa_busy;
  logic [VAL_W-1:0] sa_result;

  assign is_seq = (op_q == OP_MUL) || (op_q == OP_DIV);

  always_comb begin
    b_neg_eff = b_neg_q ^ (op_q == OP_SUB);
    a_ext     = {1'b0, a_mag_q};
    b_ext     = {1'b0, b_mag_q};
    if (a_neg_q == b_neg_eff) begin
      as_mag = a_ext + b_ext;
      as_neg = a_neg_q;
    end else if (a_ext >= b_ext) begin
      as_mag = a_ext - b_ext;
      as_neg = a_neg_q;
    end else begin
      as_mag = b_ext - a_ext;
      as_neg = b_neg_eff;
    end
    if (is_seq) begin
      res_mag = sa_result;
      res_ovf = sa_ovf;
      res_neg = a_neg_q ^ b_neg_q;
    end else begin
      res_mag = as_mag[VAL_W-1:0];
      res_ovf = as_mag > MAX_EXT;
      res_neg = as_neg;
    end
    if (res_mag == '0) res_neg = 1'b0;
  end

  // ---------------- FSM ----------------
  logic ld_digit, ld_op_a, repl_op, go_calc, chain, eq_a, finish, start_seq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ld_digit = 1'b0;
    ld_op_a  = 1'b0;
    repl_op  = 1'b0;
    go_calc  = 1'b0;
    chain    = 1'b0;
    eq_a     = 1'b0;
    finish   = 1'b0;
    if (clr_ev) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_ENTER_A, ST_SHOW: begin
          if (eq_ev) begin
            if (state_q == ST_ENTER_A) begin
              eq_a    = 1'b1;
              state_d = ST_SHOW;
            end
          end else if (op_ok) begin
            ld_op_a = 1'b1;
            state_d = ST_ENTER_B;
          end else if (dig_ok) begin
            ld_digit = 1'b1;
            state_d  = ST_ENTER_A;
          end
        end
        ST_ENTER_B: begin
          if (eq_ev) begin
            go_calc = 1'b1;
            state_d = ST_CALC;
          end else if (op_ok) begin
            if (cnt_q == '0) begin
              repl_op = 1'b1;
            end else begin
              go_calc = 1'b1;
              chain   = 1'b1;
              state_d = ST_CALC;
            end
          end else if (dig_ok) begin
            ld_digit = 1'b1;
          end
        end
        ST_CALC: begin
          if (!is_seq || sa_done) begin
            finish = 1'b1;
            if (res_ovf)      state_d = ST_ERR;
            else if (chain_q) state_d = ST_ENTER_B;
            else              state_d = ST_SHOW;
          end
        end
        default: state_d = state_q;
      endcase
    end
    start_seq = go_calc && ((op_q == OP_MUL) || (op_q == OP_DIV));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      a_mag_q     <= '0;
      a_neg_q     <= 1'b0;
      b_mag_q     <= '0;
      b_neg_q     <= 1'b0;
      op_q        <= OP_ADD;
      pend_op_q   <= OP_ADD;
      chain_q     <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else if (clr_ev) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      a_mag_q     <= '0;
      a_neg_q     <= 1'b0;
      b_mag_q     <= '0;
      b_neg_q     <= 1'b0;
      op_q        <= OP_ADD;
      pend_op_q   <= OP_ADD;
      chain_q     <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      if (ld_digit) begin
        acc_q <= dig_acc;
        cnt_q <= dig_cnt;
      end
      if (ld_op_a) begin
        if (state_q != ST_SHOW) begin
          a_mag_q <= acc_q;
          a_neg_q <= 1'b0;
        end
        op_q  <= op_val;
        acc_q <= '0;
        cnt_q <= '0;
      end
      if (repl_op) op_q <= op_val;
      if (go_calc) begin
        b_mag_q   <= b_sel;
        b_neg_q   <= b_neg_sel;
        chain_q   <= chain;
        pend_op_q <= op_val;
        acc_q     <= '0;
        cnt_q     <= '0;
      end
      if (eq_a) begin
        a_mag_q     <= acc_q;
        a_neg_q     <= 1'b0;
        res_valid_q <= 1'b1;
      end
      if (finish) begin
        if (res_ovf) begin
          err_q <= 1'b1;
        end else begin
          a_mag_q     <= res_mag;
          a_neg_q     <= res_neg;
          res_valid_q <= 1'b1;
          if (chain_q) op_q <= pend_op_q;
        end
      end
    end
  end

  calc_seqarith #(
    .VAL_W   (VAL_W),
    .MAX_VAL (MAX_VAL)
  ) u_seqarith (
    .clk    (clk),
    .rst    (rst),
    .start  (start_seq),
    .a      (a_mag_q),
    .b      (b_sel),
    .op     (op_q),
    .abort  (clr_ev),
    .done   (sa_done),
    .result (sa_result),
    .ovf    (sa_ovf),
    .busy   (sa_busy)
  );

  // ---------------- display ----------------
  always_comb begin
    disp_mag = '0;
    disp_neg = 1'b0;
    case (state_q)
      ST_IDLE, ST_ENTER_A: disp_mag = acc_q;
      ST_ENTER_B: begin
        disp_mag = (cnt_q != '0) ? acc_q : a_mag_q;
        disp_neg = (cnt_q != '0) ? 1'b0 : a_neg_q;
      end
      ST_CALC, ST_SHOW: begin
        disp_mag = a_mag_q;
        disp_neg = a_neg_q;
      end
      default: begin
        disp_mag = '0;
        disp_neg = 1'b0;
      end
    endcase
  end

  assign digit_cnt = cnt_q;
  assign state     = state_q;
  assign busy      = sa_busy;
  assign res_valid = res_valid_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_entry_core.sv
// ============================================================================
// tb_calc_entry_core : directed self-checking bench with result scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_calc_entry_core;

  localparam int DIGITS = 4;
  localparam int VAL_W  = 14;
  localparam int SYNC   = 2;

  localparam logic [2:0] S_IDLE = 3'd0, S_EA = 3'd1, S_EB = 3'd2,
                         S_CALC = 3'd3, S_SHOW = 3'd4, S_ERR = 3'd5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [15:0]       kv  = '0;
  logic [VAL_W-1:0]  disp_mag;
  logic              disp_neg;
  logic [2:0]        digit_cnt;
  logic [2:0]        state;
  logic              busy, res_valid, err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [VAL_W:0] exp_q[$];
  logic [VAL_W:0] obs_q[$];

  calc_entry_core #(.DIGITS(DIGITS), .VAL_W(VAL_W), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_digit (kv[9:0]),
    .key_op    (kv[13:10]),
    .key_eq    (kv[14]),
    .key_clr   (kv[15]),
    .disp_mag  (disp_mag),
    .disp_neg  (disp_neg),
    .digit_cnt (digit_cnt),
    .state     (state),
    .busy      (busy),
    .res_valid (res_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (res_valid) obs_q.push_back({disp_neg, disp_mag});

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] kd(input int d);   return 16'(1) << d;        endfunction
  function automatic logic [15:0] ko(input int o);   return 16'(1) << (10 + o); endfunction
  localparam logic [15:0] KEQ = 16'h4000, KCLR = 16'h8000;

  task automatic press(input logic [15:0] k, input int hold = 2);
    @(negedge clk);
    kv = k;
    tick(hold);
    kv = '0;
    tick(6);
    for (int i = 0; i < 60 && state == S_CALC; i++) tick(1);
    if (state == S_CALC) check("calc_timeout", 32'(state), 32'(S_SHOW));
  endtask

  task automatic check_disp(input string tag, input int mag, input logic neg);
    check({tag, "_mag"}, 32'(disp_mag), 32'(mag));
    check({tag, "_neg"}, 32'(disp_neg), 32'(neg));
  endtask

  initial begin
    int bc;
    int lat;
    logic [VAL_W:0] e, o;

    // reset
    tick(3);
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_disp", 32'(disp_mag), 0);
    check("rst_cnt", 32'(digit_cnt), 0);
    check("rst_flags", {29'b0, busy, res_valid, err}, 0);
    rst = 1'b0;
    tick(2);

    // 23 + 456 = 479
    press(kd(2)); press(kd(3));
    check_disp("enter23", 23, 1'b0);
    check("cnt23", 32'(digit_cnt), 2);
    check("st_ea", 32'(state), 32'(S_EA));
    press(ko(0));
    check("st_eb", 32'(state), 32'(S_EB));
    check_disp("showA", 23, 1'b0);
    press(kd(4)); press(kd(5)); press(kd(6));
    check_disp("enter456", 456, 1'b0);
    exp_q.push_back({1'b0, 14'd479});
    press(KEQ);
    check("st_show", 32'(state), 32'(S_SHOW));
    check_disp("sum479", 479, 1'b0);
    check("one_result", 32'(obs_q.size()), 1);

    // 3 - 5 = -2, then * 3 = -6, then fresh 4, eq from ENTER_A
    press(kd(3));
    check_disp("fresh3", 3, 1'b0);
    press(ko(1)); press(kd(5));
    exp_q.push_back({1'b1, 14'd2});
    press(KEQ);
    check_disp("diff", 2, 1'b1);
    press(ko(2)); press(kd(3));
    exp_q.push_back({1'b1, 14'd6});
    press(KEQ);
    check_disp("negmul", 6, 1'b1);
    press(kd(4));
    check_disp("fresh4", 4, 1'b0);
    check("st_ea4", 32'(state), 32'(S_EA));
    exp_q.push_back({1'b0, 14'd4});
    press(KEQ);
    check("st_show4", 32'(state), 32'(S_SHOW));

    // digit limit, held key, multi-digit collision, leading zero
    press(KCLR);
    check("clr_state", 32'(state), 32'(S_IDLE));
    for (int d = 1; d <= 5; d++) press(kd(d));
    check_disp("limit", 1234, 1'b0);
    check("cnt_limit", 32'(digit_cnt), 4);
    press(KCLR);
    press(kd(7), 50);
    check_disp("held7", 7, 1'b0);
    check("cnt_held", 32'(digit_cnt), 1);
    press(kd(1) | kd(2));
    check_disp("multi_dig", 7, 1'b0);
    press(KCLR);
    press(kd(0));
    check("lead0_cnt", 32'(digit_cnt), 0);
    check("lead0_state", 32'(state), 32'(S_EA));

    // 23 * 456 overflows
    press(KCLR);
    press(kd(2)); press(kd(3)); press(ko(2));
    press(kd(4)); press(kd(5)); press(kd(6));
    @(negedge clk);
    kv = KEQ;
    bc = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy) bc++;
      else if (bc > 0) break;
    end
    kv = '0;
    tick(6);
    check("mul_busy_cycles", 32'(bc), 32'(VAL_W));
    check("ovf_err", 32'(err), 1);
    check("ovf_state", 32'(state), 32'(S_ERR));
    check("ovf_disp", 32'(disp_mag), 0);
    press(kd(5));
    check("err_ignores_digit", 32'(state), 32'(S_ERR));
    press(KCLR);
    check("err_clr_state", 32'(state), 32'(S_IDLE));
    check("err_clr_err", 32'(err), 0);

    // chaining: 2 + 3 + (shows 5) 4 = 9
    press(kd(2)); press(ko(0)); press(kd(3));
    exp_q.push_back({1'b0, 14'd5});
    press(ko(0));
    check_disp("chain5", 5, 1'b0);
    check("chain_state", 32'(state), 32'(S_EB));
    press(kd(4));
    exp_q.push_back({1'b0, 14'd9});
    press(KEQ);
    check_disp("chain9", 9, 1'b0);

    // eq with no B operand reuses A: 5 + = 10
    press(KCLR);
    press(kd(5)); press(ko(0));
    exp_q.push_back({1'b0, 14'd10});
    press(KEQ);
    check_disp("reuseA", 10, 1'b0);

    // 99 * 99 = 9801
    press(KCLR);
    press(kd(9)); press(kd(9)); press(ko(2)); press(kd(9)); press(kd(9));
    exp_q.push_back({1'b0, 14'd9801});
    press(KEQ);
    check_disp("mul9801", 9801, 1'b0);

    // 9999 + 1 overflows
    press(KCLR);
    for (int i = 0; i < 4; i++) press(kd(9));
    press(ko(0)); press(kd(1)); press(KEQ);
    check("add_ovf_err", 32'(err), 1);
    check("add_ovf_state", 32'(state), 32'(S_ERR));

    // clr aborts a multiply in progress
    press(KCLR);
    press(kd(9)); press(kd(9)); press(ko(2)); press(kd(9)); press(kd(9));
    @(negedge clk);
    kv = KEQ;
    for (int i = 0; i < 20 && !busy; i++) tick(1);
    kv = '0;
    tick(2);
    check("mid_calc", 32'(state), 32'(S_CALC));
    kv = KCLR;
    lat = 0;
    for (int i = 0; i < 20 && state != S_IDLE; i++) begin tick(1); lat++; end
    check("clr_latency_ok", 32'(lat <= SYNC + 2), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_disp", {17'b0, disp_neg, disp_mag}, 0);
    check("abort_cnt_err", {28'b0, digit_cnt, err}, 0);
    kv = '0;
    tick(30);
    check("abort_no_result", 32'(state), 32'(S_IDLE));

`ifdef CALC_DIV_EN
    press(KCLR);
    press(kd(7)); press(ko(3)); press(kd(2));
    exp_q.push_back({1'b0, 14'd3});
    press(KEQ);
    check_disp("div3", 3, 1'b0);
    press(KCLR);
    press(kd(7)); press(ko(3)); press(kd(0)); press(KEQ);
    check("div0_err", 32'(err), 1);
    check("div0_state", 32'(state), 32'(S_ERR));
`else
    press(KCLR);
    press(kd(7)); press(ko(3));
    check("nodiv_state", 32'(state), 32'(S_EA));
    check_disp("nodiv_disp", 7, 1'b0);
`endif

    // scoreboard drain
    check("result_count", 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check("result", 32'(o), 32'(e));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
